mul_div_iter: RTL and testbench

//  Iterative multiply/divide unit in the EX stage; consumes the 5-bit alucontrol produced by aludec.

---
 rtl/mul_div_iter_if.sv | 27 ++
 rtl/mul_div_iter.sv | 135 +++++++++++++
 tb/tb_mul_div_iter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_iter_if.sv
// Multiply/divide unit bundle between the EX stage and mul_div_iter.
// Carries operands, control, stall and the {HI,LO} result.
interface mul_div_iter_if #(
   parameter int DATA_W = 32
);
   logic                  valid_e;
   logic [4:0]            alucontrol_e;
   logic [DATA_W-1:0]     src_a_e;
   logic [DATA_W-1:0]     src_b_e;
   logic                  flush_e;
   logic                  ready_e;
   logic                  md_stall_o;
   logic                  hilo_valid_o;
   logic [2*DATA_W-1:0]   hilo_o;

   modport master (
      output valid_e, alucontrol_e, src_a_e, src_b_e,
      output flush_e, ready_e,
      input  md_stall_o, hilo_valid_o, hilo_o
   );

   modport slave (
      input  valid_e, alucontrol_e, src_a_e, src_b_e,
      input  flush_e, ready_e,
      output md_stall_o, hilo_valid_o, hilo_o
   );
endinterface

// File: rtl/mul_div_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 cycles per op,
// magnitude datapath with sign fix-up on the final iteration.
module mul_div_iter #(
   parameter int         DATA_W   = 32,
   parameter logic [4:0] MULT_OP  = 5'b10000,
   parameter logic [4:0] MULTU_OP = 5'b10001,
   parameter logic [4:0] DIV_OP   = 5'b10010,
   parameter logic [4:0] DIVU_OP  = 5'b10011
) (
   input logic           clk,
   input logic           resetn,
   mul_div_iter_if.slave md
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [4:0]          cnt;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W:0]     rem;
   logic [DATA_W-1:0]   opb;
   logic                neg_q, neg_r, div0;
   logic [2*DATA_W-1:0] hilo;
   logic                hv;

   logic                is_mult, is_div, is_sgn, start, busy, last;
   logic [DATA_W-1:0]   abs_a, abs_b;
   logic [DATA_W:0]     mul_sum, div_sh;
   logic [2*DATA_W-1:0] mul_nxt, prod_fix, hilo_nxt;
   logic                div_ge;
   logic [DATA_W:0]     div_r;
   logic [DATA_W-1:0]   div_q, q_fix, r_fix;

   assign md.md_stall_o   = start | busy;
   assign md.hilo_valid_o = hv;
   assign md.hilo_o       = hilo;

   // Decode the op, form operand magnitudes and one iteration step.
   always_comb begin
      is_mult = (md.alucontrol_e == MULT_OP) |
                (md.alucontrol_e == MULTU_OP);
      is_div  = (md.alucontrol_e == DIV_OP) |
                (md.alucontrol_e == DIVU_OP);
      is_sgn  = (md.alucontrol_e == MULT_OP) |
                (md.alucontrol_e == DIV_OP);
      abs_a   = (is_sgn & md.src_a_e[DATA_W-1]) ?
                -md.src_a_e : md.src_a_e;
      abs_b   = (is_sgn & md.src_b_e[DATA_W-1]) ?
                -md.src_b_e : md.src_b_e;
      start   = md.valid_e & (is_mult | is_div) &
                ~md.flush_e & (state == S_IDLE);
      busy    = (state == S_MUL) | (state == S_DIV);
      last    = (cnt == 5'd31);
      mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} +
                (acc[0] ? {1'b0, opb} : '0);
      mul_nxt = {mul_sum, acc[DATA_W-1:1]};
      div_sh  = {rem[DATA_W-1:0], acc[DATA_W-1]};
      div_ge  = div_sh >= {1'b0, opb};
      div_r   = div_ge ? div_sh - {1'b0, opb} : div_sh;
      div_q   = {acc[DATA_W-2:0], div_ge};
      prod_fix = neg_q ? -mul_nxt : mul_nxt;
      q_fix    = (neg_q & ~div0) ? -div_q : div_q;
      r_fix    = neg_r ? -div_r[DATA_W-1:0] :
                 div_r[DATA_W-1:0];
      hilo_nxt = (state == S_MUL) ? prod_fix :
                 {r_fix, q_fix};
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next state: flush wins over every other transition.
   always_comb begin
      state_nxt = state;
      if (md.flush_e) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start)
                       state_nxt = is_mult ? S_MUL : S_DIV;
            S_MUL,
            S_DIV:  if (last) state_nxt = S_DONE;
            S_DONE: if (md.ready_e) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Operand latch, iteration and result/valid registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt   <= '0;
         acc   <= '0;
         rem   <= '0;
         opb   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         div0  <= 1'b0;
         hilo  <= '0;
         hv    <= 1'b0;
      end else begin
         if (start) begin
            cnt   <= '0;
            rem   <= '0;
            acc   <= {{DATA_W{1'b0}}, is_mult ? abs_b : abs_a};
            opb   <= is_mult ? abs_a : abs_b;
            neg_q <= is_sgn &
                     (md.src_a_e[DATA_W-1] ^ md.src_b_e[DATA_W-1]);
            neg_r <= is_sgn & is_div & md.src_a_e[DATA_W-1];
            div0  <= is_div & (md.src_b_e == '0);
         end else if (busy && !md.flush_e) begin
            cnt <= cnt + 5'd1;
            if (state == S_MUL) begin
               acc <= mul_nxt;
            end else begin
               acc[DATA_W-1:0] <= div_q;
               rem             <= div_r;
            end
            if (last) begin
               hilo <= hilo_nxt;
               hv   <= 1'b1;
            end
         end
         if (md.flush_e || (state == S_DONE && md.ready_e))
            hv <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mul_div_iter.sv
// Directed and random checks of mul_div_iter against
// a plain-arithmetic reference of MULT/MULTU/DIV/DIVU.
module tb_mul_div_iter;
   localparam logic [4:0] OP_MULT  = 5'b10000;
   localparam logic [4:0] OP_MULTU = 5'b10001;
   localparam logic [4:0] OP_DIV   = 5'b10010;
   localparam logic [4:0] OP_DIVU  = 5'b10011;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mul_div_iter_if #(.DATA_W(32)) bus ();

   mul_div_iter #(
      .DATA_W  (32),
      .MULT_OP (OP_MULT),
      .MULTU_OP(OP_MULTU),
      .DIV_OP  (OP_DIV),
      .DIVU_OP (OP_DIVU)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .md    (bus)
   );

   function automatic logic [63:0] ref_md(
      input logic [4:0] op, input logic [31:0] a, b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      if (op == OP_MULT) begin
         res = 64'(sa * sb);
      end else if (op == OP_MULTU) begin
         res = {32'd0, a} * {32'd0, b};
      end else if (b == 32'd0) begin
         res = {a, 32'hFFFF_FFFF};
      end else if (op == OP_DIVU) begin
         res = {a % b, a / b};
      end else begin
         q = sa / sb;
         r = sa % sb;
         res = {r[31:0], q[31:0]};
      end
      return res;
   endfunction

   task automatic chk(input string tag,
                      input logic [63:0] obs, exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] op,
                        input logic [31:0] a, b);
      bus.valid_e      = v;
      bus.alucontrol_e = op;
      bus.src_a_e      = a;
      bus.src_b_e      = b;
   endtask

   task automatic run_op(input string tag, input logic [4:0] op,
                         input logic [31:0] a, b, input int hold);
      logic [63:0] exp;
      int n, t;
      exp = ref_md(op, a, b);
      @(negedge clk);
      drive(1'b1, op, a, b);
      bus.ready_e = 1'b0;
      bus.flush_e = 1'b0;
      #1;
      n = 0;
      t = 0;
      while (bus.hilo_valid_o !== 1'b1 && t < 100) begin
         if (bus.md_stall_o === 1'b1) n++;
         @(negedge clk);
         t++;
      end
      chk({tag, ".latency"}, 64'(t), 64'd33);
      chk({tag, ".stall_cycles"}, 64'(n), 64'd33);
      chk({tag, ".hilo"}, bus.hilo_o, exp);
      chk({tag, ".done_stall"}, 64'(bus.md_stall_o), 64'd0);
      repeat (hold) begin
         @(negedge clk);
         chk({tag, ".hold_hilo"}, bus.hilo_o, exp);
         chk({tag, ".hold_valid"}, 64'(bus.hilo_valid_o), 64'd1);
         chk({tag, ".hold_stall"}, 64'(bus.md_stall_o), 64'd0);
      end
      bus.ready_e = 1'b1;
      @(negedge clk);
      bus.ready_e = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 32'd0);
      #1;
      chk({tag, ".exit_valid"}, 64'(bus.hilo_valid_o), 64'd0);
      chk({tag, ".exit_keep"}, bus.hilo_o, exp);
   endtask

   initial begin
      logic [4:0] ops [4];
      logic [4:0] op;
      logic [31:0] ra, rb;
      int seen;
      ops[0] = OP_MULT;
      ops[1] = OP_MULTU;
      ops[2] = OP_DIV;
      ops[3] = OP_DIVU;
      drive(1'b0, 5'd0, 32'd0, 32'd0);
      bus.flush_e = 1'b0;
      bus.ready_e = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset.hilo", bus.hilo_o, 64'd0);
      chk("reset.valid", 64'(bus.hilo_valid_o), 64'd0);
      chk("reset.stall", 64'(bus.md_stall_o), 64'd0);
      resetn = 1'b1;

      run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 0);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("divu_by0", OP_DIVU, 32'h1234, 32'd0, 0);
      run_op("div_neg_by0", OP_DIV, 32'hFFFF_FF00, 32'd0, 0);
      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 5);

      @(negedge clk);
      drive(1'b1, 5'b00001, 32'd3, 32'd4);
      #1;
      chk("nonmd.stall", 64'(bus.md_stall_o), 64'd0);
      @(negedge clk);
      chk("nonmd.stall2", 64'(bus.md_stall_o), 64'd0);
      chk("nonmd.valid", 64'(bus.hilo_valid_o), 64'd0);

      drive(1'b1, OP_DIV, 32'd9, 32'd2);
      bus.flush_e = 1'b1;
      #1;
      chk("flush_start.stall", 64'(bus.md_stall_o), 64'd0);
      @(negedge clk);
      bus.flush_e = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 32'd0);
      #1;
      chk("flush_start.idle", 64'(bus.md_stall_o), 64'd0);

      @(negedge clk);
      drive(1'b1, OP_MULT, 32'd11, 32'd13);
      repeat (11) @(negedge clk);
      chk("flush_mid.busy", 64'(bus.md_stall_o), 64'd1);
      bus.flush_e = 1'b1;
      @(negedge clk);
      bus.flush_e = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 32'd0);
      #1;
      chk("flush_mid.stall", 64'(bus.md_stall_o), 64'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.hilo_valid_o !== 1'b0) seen++;
      end
      chk("flush_mid.no_valid", 64'(seen), 64'd0);
      run_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 0);

      @(negedge clk);
      drive(1'b1, OP_MULT, 32'd123, 32'd456);
      repeat (21) @(negedge clk);
      resetn = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("rst_mid.hilo", bus.hilo_o, 64'd0);
      chk("rst_mid.valid", 64'(bus.hilo_valid_o), 64'd0);
      chk("rst_mid.stall", 64'(bus.md_stall_o), 64'd0);
      resetn = 1'b1;

      for (int i = 0; i < 24; i++) begin
         op = ops[$urandom_range(0, 3)];
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: begin
               ra = 32'h8000_0000;
               rb = 32'hFFFF_FFFF;
            end
            3: ra = 32'($urandom_range(0, 255));
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), op, ra, rb, i % 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
